// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: data widths, FIFO depth and header field layout.
package router_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned NUM_PORTS = 3;

    // Header byte layout: [1:0] destination address, [7:2] payload length.
    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_LEN_MSB  = 7;

endpackage : router_pkg

// File: rtl/router_fifo_mem.sv
// Register-array storage for the router FIFO: one synchronous write port, asynchronous read.
module router_fifo_mem #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : router_fifo_mem

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router; flags the parity byte of each packet on read.
module router_fifo
    import router_pkg::*;
#(
    parameter int unsigned DATA_W = router_pkg::DATA_W,
    parameter int unsigned DEPTH  = router_pkg::DEPTH,
    parameter int unsigned LEN_W  = router_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_done
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PTR_W  = AW + 1;
    localparam int unsigned WORD_W = DATA_W + 1;
    localparam int unsigned CNT_W  = LEN_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [WORD_W-1:0] rd_word;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_is_hdr;
    logic [LEN_W-1:0]  rd_len;

    router_fifo_mem #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({lfd_state, data_in}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word)
    );

    // Flags and accept strobes derived from the registered pointers.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        wr_acc    = write_enb && !full && !soft_reset;
        rd_acc    = read_enb && !empty && !soft_reset;
        rd_is_hdr = rd_word[DATA_W];
        rd_len    = rd_word[HDR_LEN_MSB:HDR_LEN_LSB];
    end

    // Pointer, read-data and packet-boundary tracking; soft_reset flushes everything but memory.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            data_out <= '0;
            pkt_done <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            data_out <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= rd_word[DATA_W-1:0];
                if (rd_is_hdr) begin
                    // Length plus the trailing parity byte; a new header always reloads.
                    pkt_cnt <= CNT_W'(rd_len) + CNT_W'(1);
                end else if (pkt_cnt != '0) begin
                    pkt_cnt <= pkt_cnt - CNT_W'(1);
                    if (pkt_cnt == CNT_W'(1)) begin
                        pkt_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule : router_fifo

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: table vectors, directed corner sequences, random vs queue model.
module tb_router_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_done;

    int vectors;
    int miscompares;

    // Reference model: queue of {header flag, byte} plus packet bookkeeping.
    logic [8:0] q[$];
    logic [7:0] m_dout;
    int         m_remaining;
    logic       m_done;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       lfd;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_done;
    } vec_t;

    vec_t tbl[11];

    router_fifo dut (
        .clk        (clk),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_done   (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_dout      = 8'h00;
        m_remaining = 0;
        m_done      = 1'b0;
    endtask

    // One clock edge of the model, using occupancy sampled before the edge.
    task automatic model_step(input logic w, input logic r, input logic l, input logic s,
                              input logic [7:0] d);
        logic [8:0] word;
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (s) begin
            model_clear();
            return;
        end
        m_done = 1'b0;
        if (r && !was_empty) begin
            word   = q.pop_front();
            m_dout = word[7:0];
            if (word[8]) begin
                m_remaining = int'(word[7:2]) + 1;
            end else if (m_remaining > 0) begin
                m_remaining = m_remaining - 1;
                if (m_remaining == 0) m_done = 1'b1;
            end
        end
        if (w && !was_full) q.push_back({l, d});
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
        chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        chk({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
        chk({tag, ".pkt_done"}, 32'(pkt_done), 32'(m_done));
    endtask

    task automatic apply(input string tag, input logic w, input logic r, input logic l,
                         input logic s, input logic [7:0] d);
        write_enb  = w;
        read_enb   = r;
        lfd_state  = l;
        soft_reset = s;
        data_in    = d;
        @(posedge clk);
        model_step(w, r, l, s, d);
        #1;
        check_model(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        soft_reset  = 1'b0;
        write_enb   = 1'b0;
        read_enb    = 1'b0;
        lfd_state   = 1'b0;
        data_in     = 8'h00;
        model_clear();

        // Header 0x0C (len 3) + 3 payload + parity, then read all five and one read on empty.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0};

        #12;
        resetn = 1'b1;
        chk("reset.data_out", 32'(data_out), 32'h0);
        chk("reset.full",     32'(full),     32'h0);
        chk("reset.empty",    32'(empty),    32'h1);
        chk("reset.pkt_done", 32'(pkt_done), 32'h0);

        foreach (tbl[i]) begin
            apply("tbl", tbl[i].wr, tbl[i].rd, tbl[i].lfd, 1'b0, tbl[i].din);
            chk($sformatf("tbl%0d.data_out", i), 32'(data_out), 32'(tbl[i].exp_dout));
            chk($sformatf("tbl%0d.full", i),     32'(full),     32'(tbl[i].exp_full));
            chk($sformatf("tbl%0d.empty", i),    32'(empty),    32'(tbl[i].exp_empty));
            chk($sformatf("tbl%0d.pkt_done", i), 32'(pkt_done), 32'(tbl[i].exp_done));
        end

        // Fill to full, drop the 17th write, drain in order.
        for (int i = 1; i <= 16; i++) apply("fill", 1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
        chk("fill.full16", 32'(full), 32'h1);
        apply("drop", 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        chk("drop.full", 32'(full), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            apply("drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("drain%0d.data", i), 32'(data_out), 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'h1);

        // Steady-state streaming with 8 entries across pointer wrap.
        for (int i = 0; i < 8; i++) apply("pre8", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i));
        for (int k = 0; k < 20; k++) begin
            apply("stream", 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + k));
            chk("stream.occupancy", 32'({full, empty}), 32'h0);
            chk("stream.data", 32'(data_out), 32'((k < 8) ? (8'h80 + k) : (8'h40 + k - 8)));
        end

        // Full with simultaneous read and write: oldest word out, write dropped.
        for (int i = 0; i < 8; i++) apply("top", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hC0 + i));
        chk("top.full", 32'(full), 32'h1);
        apply("fullrw", 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
        chk("fullrw.data", 32'(data_out), 32'h4C);
        chk("fullrw.full", 32'(full), 32'h0);
        for (int i = 0; i < 15; i++) apply("fullrw_drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("fullrw.last", 32'(data_out), 32'hC7);

        // Mid-packet soft reset with simultaneous read/write.
        apply("sr_hdr", 1'b1, 1'b0, 1'b1, 1'b0, 8'h08);
        apply("sr_pay", 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        apply("sr_rd",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        apply("sr",     1'b1, 1'b1, 1'b0, 1'b1, 8'h99);
        chk("sr.empty", 32'(empty), 32'h1);
        chk("sr.data",  32'(data_out), 32'h0);
        chk("sr.done",  32'(pkt_done), 32'h0);
        apply("sr_wr",  1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
        apply("sr_rd2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("sr.first", 32'(data_out), 32'h3C);
        chk("sr.orphan_nodone", 32'(pkt_done), 32'h0);

        // Zero-length header: next byte is parity.
        apply("z_hdr", 1'b1, 1'b0, 1'b1, 1'b0, 8'h01);
        apply("z_par", 1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        apply("z_rd1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("z.hdr_nodone", 32'(pkt_done), 32'h0);
        apply("z_rd2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("z.par_data", 32'(data_out), 32'h77);
        chk("z.par_done", 32'(pkt_done), 32'h1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            apply("rand",
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 63) == 0),
                  8'($urandom));
        end

        // Asynchronous reset between edges with 5 entries held.
        apply("ar_flush", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) apply("ar_fill", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hD1 + i));
        apply("ar_rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        model_clear();
        chk("areset.empty", 32'(empty),    32'h1);
        chk("areset.full",  32'(full),     32'h0);
        chk("areset.data",  32'(data_out), 32'h0);
        chk("areset.done",  32'(pkt_done), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        apply("post_ar", 1'b1, 1'b0, 1'b0, 1'b0, 8'h5C);
        apply("post_ar_rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("post_ar.data", 32'(data_out), 32'h5C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_router_fifo
